// File: rtl/l2_amo_alu_pipe_if.sv
// Request/response bundle for the pipelined L2 AMO ALU.
//
// Handshake: a request transfers on a rising clk edge where in_valid and
// in_ready are both high; a result transfers on an edge where out_valid and
// out_ready are both high. A valid side must hold its payload unchanged
// until the transfer happens. in_ready never depends on in_valid.
interface l2_amo_alu_pipe_if #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 40
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_op;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [2:0]            in_size;
  logic [LINE_WIDTH-1:0] in_mem_line;
  logic [LINE_WIDTH-1:0] in_cpu_line;
  logic [LINE_WIDTH-1:0] in_cmp_line;
  logic                  out_valid;
  logic                  out_ready;
  logic [LINE_WIDTH-1:0] out_line;
  logic [63:0]           out_old;
  logic                  out_cas_hit;
  logic                  out_misaligned;

  modport master (
    output in_valid, in_op, in_addr, in_size, in_mem_line, in_cpu_line,
           in_cmp_line, out_ready,
    input  in_ready, out_valid, out_line, out_old, out_cas_hit, out_misaligned
  );

  modport slave (
    input  in_valid, in_op, in_addr, in_size, in_mem_line, in_cpu_line,
           in_cmp_line, out_ready,
    output in_ready, out_valid, out_line, out_old, out_cas_hit, out_misaligned
  );
endinterface

// File: rtl/l2_amo_alu_pipe.sv
// Two-stage, flow-controlled AMO ALU. S1 picks the addressed dword, undoes
// the per-dword byte order and MSB-aligns the element of each operand; S2
// runs the ALU, merges the element back and restores the byte order.
module l2_amo_alu_pipe #(
  parameter int LINE_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 40,
  parameter bit SWAP_ENDIANESS = 1'b1
) (
  input logic               clk,
  input logic               rst,
  l2_amo_alu_pipe_if.slave  bus
);

  localparam int NDW   = LINE_WIDTH / 64;
  localparam int IDX_W = (NDW > 1) ? $clog2(NDW) : 1;

  function automatic logic [63:0] bswap64(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] to_logical(input logic [63:0] d);
    return SWAP_ENDIANESS ? bswap64(d) : d;
  endfunction

  function automatic logic [3:0] size_bytes(input logic [2:0] sz);
    case (sz)
      3'b001:  return 4'd1;
      3'b010:  return 4'd2;
      3'b011:  return 4'd4;
      3'b100:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  // ---------------- flow control ----------------
  logic s1_valid, s2_valid, s1_adv, s2_adv;
  assign s2_adv       = ~s2_valid | bus.out_ready;
  assign s1_adv       = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv;

  // ---------------- stage 0 (combinational select/align) ----------------
  logic [IDX_W-1:0] in_idx;
  logic [3:0]       in_nb;
  logic [5:0]       in_rsh;
  logic [6:0]       in_lsh;
  logic             in_mis;
  logic             unused_addr_bits;

  assign in_idx = (NDW > 1) ? bus.in_addr[IDX_W+2:3] : '0;
  assign in_nb  = size_bytes(bus.in_size);
  assign in_rsh = {bus.in_addr[2:0], 3'b000};
  assign in_lsh = 7'd64 - {in_nb, 3'b000};
  assign unused_addr_bits = ^bus.in_addr[ADDR_WIDTH-1:IDX_W+3];

  // Element must sit on a multiple of its own size inside the dword.
  always_comb begin
    in_mis = 1'b0;
    case (bus.in_size)
      3'b010:  in_mis = bus.in_addr[0];
      3'b011:  in_mis = |bus.in_addr[1:0];
      3'b100:  in_mis = |bus.in_addr[2:0];
      default: in_mis = 1'b0;
    endcase
  end

  // Element of a line, moved to the top of 64 bits with zeros below.
  function automatic logic [63:0] msb_elem(input logic [LINE_WIDTH-1:0] line,
                                           input logic [IDX_W-1:0] idx,
                                           input logic [5:0] rsh,
                                           input logic [6:0] lsh);
    logic [63:0] ld;
    ld = to_logical(line[64*int'(idx) +: 64]);
    return (ld >> rsh) << lsh;
  endfunction

  // ---------------- stage 1 registers ----------------
  logic [63:0]           s1_a, s1_b, s1_c;
  logic [LINE_WIDTH-1:0] s1_line;
  logic [IDX_W-1:0]      s1_idx;
  logic [2:0]            s1_off;
  logic [2:0]            s1_size;
  logic [3:0]            s1_op;
  logic                  s1_mis;

  // S1 capture: load a new request whenever the stage can move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_line  <= '0;
      s1_idx   <= '0;
      s1_off   <= '0;
      s1_size  <= '0;
      s1_op    <= '0;
      s1_mis   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a    <= msb_elem(bus.in_mem_line, in_idx, in_rsh, in_lsh);
        s1_b    <= msb_elem(bus.in_cpu_line, in_idx, in_rsh, in_lsh);
        s1_c    <= msb_elem(bus.in_cmp_line, in_idx, in_rsh, in_lsh);
        s1_line <= bus.in_mem_line;
        s1_idx  <= in_idx;
        s1_off  <= bus.in_addr[2:0];
        s1_size <= bus.in_size;
        s1_op   <= bus.in_op;
        s1_mis  <= in_mis;
      end
    end
  end

  // ---------------- stage 2 (combinational ALU/merge) ----------------
  logic [3:0]  s2_nb;
  logic [6:0]  s2_lsh;
  logic [5:0]  s2_rsh;
  logic [63:0] s2_mask;
  logic [64:0] diff_s, diff_u;
  logic        lt_s, lt_u, eq_ab;
  logic [63:0] res;
  logic        cas_hit, keep;

  assign s2_nb   = size_bytes(s1_size);
  assign s2_lsh  = 7'd64 - {s2_nb, 3'b000};
  assign s2_rsh  = {s1_off, 3'b000};
  assign s2_mask = ~64'd0 << s2_lsh;
  assign diff_s  = {s1_a[63], s1_a} - {s1_b[63], s1_b};
  assign diff_u  = {1'b0, s1_a} - {1'b0, s1_b};
  assign lt_s    = diff_s[64];
  assign lt_u    = diff_u[64];
  assign eq_ab   = (s1_a == s1_b);

  // ALU on MSB-aligned operands: carries and compares see only the element.
  always_comb begin
    res     = s1_a;
    cas_hit = 1'b0;
    keep    = 1'b0;
    case (s1_op)
      4'd1:  res = s1_a + s1_b;
      4'd2:  res = s1_a & s1_b;
      4'd3:  res = s1_a | s1_b;
      4'd4:  res = s1_a ^ s1_b;
      4'd5:  res = lt_s ? s1_b : s1_a;
      4'd6:  res = lt_u ? s1_b : s1_a;
      4'd7:  res = (lt_s | eq_ab) ? s1_a : s1_b;
      4'd8:  res = (lt_u | eq_ab) ? s1_a : s1_b;
      4'd9:  res = s1_b;
      4'd10: begin
        cas_hit = (s1_a == s1_c);
        res     = cas_hit ? s1_b : s1_a;
      end
      default: keep = 1'b1;
    endcase
    if (s1_mis || s2_nb == 4'd0) begin
      keep    = 1'b1;
      cas_hit = 1'b0;
    end
  end

  logic [63:0]           old_dw, ld, pos_mask, new_ld;
  logic [LINE_WIDTH-1:0] line_d;

  // Merge: replace only the element bytes, then restore raw byte order.
  always_comb begin
    old_dw   = s1_line[64*int'(s1_idx) +: 64];
    ld       = to_logical(old_dw);
    pos_mask = (s2_mask >> s2_lsh) << s2_rsh;
    new_ld   = (ld & ~pos_mask) | (((res >> s2_lsh) << s2_rsh) & pos_mask);
    line_d   = s1_line;
    if (!keep) line_d[64*int'(s1_idx) +: 64] = to_logical(new_ld);
  end

  // ---------------- stage 2 registers / outputs ----------------
  logic [LINE_WIDTH-1:0] s2_line;
  logic [63:0]           s2_old;
  logic                  s2_hit, s2_mis;

  // S2 capture: results hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_line  <= '0;
      s2_old   <= '0;
      s2_hit   <= 1'b0;
      s2_mis   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_line <= line_d;
        s2_old  <= old_dw;
        s2_hit  <= cas_hit;
        s2_mis  <= s1_mis;
      end
    end
  end

  assign bus.out_valid      = s2_valid;
  assign bus.out_line       = s2_line;
  assign bus.out_old        = s2_old;
  assign bus.out_cas_hit    = s2_hit;
  assign bus.out_misaligned = s2_mis;

endmodule

// File: tb/tb_l2_amo_alu_pipe.sv
// Bench for l2_amo_alu_pipe: one little-endian and one byte-swapped
// instance driven in lockstep, checked against a byte-addressed model.
module tb_l2_amo_alu_pipe;
  localparam int LW = 128;
  localparam int AW = 40;
  localparam int EW = LW + 64 + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_amo_alu_pipe_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus0 ();
  l2_amo_alu_pipe_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus1 ();

  l2_amo_alu_pipe #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .SWAP_ENDIANESS(1'b0))
    u_dut_le (.clk(clk), .rst(rst), .bus(bus0));
  l2_amo_alu_pipe #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .SWAP_ENDIANESS(1'b1))
    u_dut_be (.clk(clk), .rst(rst), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*EW-1:0] exp_q[$];

  logic rdy_rand = 1'b0;
  logic rdy_val  = 1'b1;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Line viewed as bytes; element byte k of address A lives at raw byte
  // dw*8+off+k (little-endian dwords) or dw*8+7-(off+k) (big-endian dwords).
  function automatic logic [EW-1:0] model(input bit swp, input logic [3:0] op,
                                          input logic [AW-1:0] addr, input logic [2:0] size,
                                          input logic [LW-1:0] mem, input logic [LW-1:0] cpu,
                                          input logic [LW-1:0] cmp);
    int nb, dw, off, p;
    logic [63:0] a, b, c, r, mask, old;
    longint sa, sb;
    logic [LW-1:0] line;
    logic hit, mis;
    case (size)
      3'd1: nb = 1;
      3'd2: nb = 2;
      3'd3: nb = 4;
      3'd4: nb = 8;
      default: nb = 0;
    endcase
    off  = int'(addr[2:0]);
    dw   = (int'(addr[7:0]) % (LW/8)) / 8;
    line = mem;
    old  = mem[dw*64 +: 64];
    hit  = 1'b0;
    mis  = (nb > 1) && (off % nb != 0);
    if (!mis && nb != 0 && op >= 4'd1 && op <= 4'd10) begin
      a = '0; b = '0; c = '0;
      for (int k = 0; k < nb; k++) begin
        p = dw*8 + (swp ? 7 - (off + k) : off + k);
        a[8*k +: 8] = mem[8*p +: 8];
        b[8*k +: 8] = cpu[8*p +: 8];
        c[8*k +: 8] = cmp[8*p +: 8];
      end
      mask = (nb == 8) ? ~64'd0 : ((64'd1 << (8*nb)) - 64'd1);
      sa = (a[8*nb-1] && nb < 8) ? longint'(a | ~mask) : longint'(a);
      sb = (b[8*nb-1] && nb < 8) ? longint'(b | ~mask) : longint'(b);
      case (op)
        4'd1: r = (a + b) & mask;
        4'd2: r = a & b;
        4'd3: r = a | b;
        4'd4: r = a ^ b;
        4'd5: r = (sb > sa) ? b : a;
        4'd6: r = (b > a) ? b : a;
        4'd7: r = (sb < sa) ? b : a;
        4'd8: r = (b < a) ? b : a;
        4'd9: r = b;
        default: begin
          hit = (a == c);
          r   = hit ? b : a;
        end
      endcase
      for (int k = 0; k < nb; k++) begin
        p = dw*8 + (swp ? 7 - (off + k) : off + k);
        line[8*p +: 8] = r[8*k +: 8];
      end
    end
    return {line, old, hit, mis};
  endfunction

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    bus0.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    bus1.out_ready = bus0.out_ready;
  end

  task automatic drive_req(input logic [3:0] op, input logic [AW-1:0] addr, input logic [2:0] size,
                           input logic [LW-1:0] mem, input logic [LW-1:0] cpu, input logic [LW-1:0] cmp);
    int  waited;
    logic acc;
    bus0.in_op = op;   bus0.in_addr = addr; bus0.in_size = size;
    bus0.in_mem_line = mem; bus0.in_cpu_line = cpu; bus0.in_cmp_line = cmp;
    bus1.in_op = op;   bus1.in_addr = addr; bus1.in_size = size;
    bus1.in_mem_line = mem; bus1.in_cpu_line = cpu; bus1.in_cmp_line = cmp;
    bus0.in_valid = 1'b1;
    bus1.in_valid = 1'b1;
    waited = 0;
    acc    = 1'b0;
    while (!acc && waited < 200) begin
      @(negedge clk);
      if (bus0.in_ready) acc = 1'b1;
      else waited++;
    end
    check("accepted", LW'(acc), LW'(1));
    if (acc) begin
      @(posedge clk);
      exp_q.push_back({model(1'b0, op, addr, size, mem, cpu, cmp),
                       model(1'b1, op, addr, size, mem, cpu, cmp)});
    end
    #1;
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
  endtask

  task automatic rand_req();
    logic [3:0]    op;
    logic [2:0]    size;
    logic [AW-1:0] addr;
    logic [LW-1:0] mem, cpu, cmp;
    int nb;
    op   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
    size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
    addr = {8'($urandom), $urandom};
    nb   = (size == 3'd1) ? 1 : (size == 3'd2) ? 2 : (size == 3'd3) ? 4 : 8;
    if ($urandom_range(0, 4) != 0) addr = addr & ~AW'(nb - 1);
    mem = {$urandom, $urandom, $urandom, $urandom};
    cpu = {$urandom, $urandom, $urandom, $urandom};
    cmp = ($urandom_range(0, 1) == 1) ? mem : {$urandom, $urandom, $urandom, $urandom};
    drive_req(op, addr, size, mem, cpu, cmp);
  endtask

  task automatic wait_valid();
    int w;
    w = 0;
    @(negedge clk);
    while (!bus0.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("out_timeout", LW'(bus0.out_valid), LW'(1));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    check("drain_empty", LW'(exp_q.size()), LW'(0));
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic            stall_prev = 1'b0;
  logic [LW-1:0]   snap_line;
  logic [63:0]     snap_old;
  logic [2*EW-1:0] e;
  logic [EW-1:0]   e_le, e_be;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && bus0.out_valid) begin
        check("hold_line", bus0.out_line, snap_line);
        check("hold_old", LW'(bus0.out_old), LW'(snap_old));
      end
      if (bus0.out_valid && bus0.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", LW'(bus0.out_valid), LW'(0));
        end else begin
          e    = exp_q.pop_front();
          e_le = e[2*EW-1:EW];
          e_be = e[EW-1:0];
          check("le_line", bus0.out_line, e_le[EW-1:66]);
          check("le_old", LW'(bus0.out_old), LW'(e_le[65:2]));
          check("le_hit", LW'(bus0.out_cas_hit), LW'(e_le[1]));
          check("le_mis", LW'(bus0.out_misaligned), LW'(e_le[0]));
          check("be_valid", LW'(bus1.out_valid), LW'(1));
          check("be_line", bus1.out_line, e_be[EW-1:66]);
          check("be_old", LW'(bus1.out_old), LW'(e_be[65:2]));
          check("be_hit", LW'(bus1.out_cas_hit), LW'(e_be[1]));
          check("be_mis", LW'(bus1.out_misaligned), LW'(e_be[0]));
        end
      end
      stall_prev = bus0.out_valid && !bus0.out_ready;
      snap_line  = bus0.out_line;
      snap_old   = bus0.out_old;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [LW-1:0] mem, cpu, cmp;

  initial begin
    bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
    bus0.in_op = '0; bus0.in_addr = '0; bus0.in_size = '0;
    bus0.in_mem_line = '0; bus0.in_cpu_line = '0; bus0.in_cmp_line = '0;
    bus1.in_op = '0; bus1.in_addr = '0; bus1.in_size = '0;
    bus1.in_mem_line = '0; bus1.in_cpu_line = '0; bus1.in_cmp_line = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_valid", LW'(bus0.out_valid), LW'(0));
    check("rst_line", bus0.out_line, LW'(0));
    check("rst_old", LW'(bus0.out_old), LW'(0));
    check("rst_hit", LW'(bus0.out_cas_hit), LW'(0));
    check("rst_mis", LW'(bus0.out_misaligned), LW'(0));
    check("rst_be_valid", LW'(bus1.out_valid), LW'(0));
    @(negedge clk);
    check("rst_in_ready", LW'(bus0.in_ready), LW'(1));
    @(posedge clk);
    #1;

    // ADD 8B on dword 1, wrap to 1, latency 2
    mem = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF};
    cpu = {64'h2, 64'h5555_5555_5555_5555};
    drive_req(4'd1, 40'h8, 3'b100, mem, cpu, '0);
    @(negedge clk);
    check("lat_first_cycle", LW'(bus0.out_valid), LW'(0));
    @(negedge clk);
    check("lat_second_cycle", LW'(bus0.out_valid), LW'(1));
    check("add_dw1", LW'(bus0.out_line[127:64]), LW'(64'h1));
    check("add_dw0", LW'(bus0.out_line[63:0]), LW'(64'h0123_4567_89AB_CDEF));
    check("add_old", LW'(bus0.out_old), LW'(64'hFFFF_FFFF_FFFF_FFFF));
    @(posedge clk);
    #1;

    // MIN / MINU 1B at byte 3
    mem = {$urandom, $urandom, $urandom, $urandom};
    cpu = {$urandom, $urandom, $urandom, $urandom};
    mem[31:24] = 8'h80;
    cpu[31:24] = 8'h7F;
    drive_req(4'd7, 40'h3, 3'b001, mem, cpu, '0);
    wait_valid();
    check("min_byte", LW'(bus0.out_line[31:24]), LW'(8'h80));
    check("min_line", bus0.out_line, mem);
    @(posedge clk);
    #1;
    drive_req(4'd8, 40'h3, 3'b001, mem, cpu, '0);
    wait_valid();
    check("minu_byte", LW'(bus0.out_line[31:24]), LW'(8'h7F));
    check("minu_rest", LW'({bus0.out_line[LW-1:32], bus0.out_line[23:0]}),
          LW'({mem[LW-1:32], mem[23:0]}));
    @(posedge clk);
    #1;

    // CAS 4B hit and miss
    mem = {$urandom, $urandom, $urandom, 32'h1234_5678};
    cpu = {$urandom, $urandom, $urandom, 32'hDEAD_BEEF};
    cmp = {$urandom, $urandom, $urandom, 32'h1234_5678};
    drive_req(4'd10, 40'h0, 3'b011, mem, cpu, cmp);
    wait_valid();
    check("cas_word", LW'(bus0.out_line[31:0]), LW'(32'hDEAD_BEEF));
    check("cas_hit", LW'(bus0.out_cas_hit), LW'(1));
    @(posedge clk);
    #1;
    cmp[31:0] = 32'h0;
    drive_req(4'd10, 40'h0, 3'b011, mem, cpu, cmp);
    wait_valid();
    check("cas_miss_line", bus0.out_line, mem);
    check("cas_miss_hit", LW'(bus0.out_cas_hit), LW'(0));
    @(posedge clk);
    #1;

    // MAXU 4B misaligned
    mem = {$urandom, $urandom, $urandom, $urandom};
    cpu = {$urandom, $urandom, $urandom, $urandom};
    drive_req(4'd6, 40'h12, 3'b011, mem, cpu, '0);
    wait_valid();
    check("mis_flag", LW'(bus0.out_misaligned), LW'(1));
    check("mis_line", bus0.out_line, mem);
    @(posedge clk);
    #1;
    drain();

    // back-to-back with consumer stall on cycles 3-5
    fork
      begin
        for (int i = 0; i < 6; i++) rand_req();
      end
      begin
        repeat (2) @(posedge clk);
        rdy_val = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", LW'(bus0.in_ready), LW'(0));
        end
        @(posedge clk);
        rdy_val = 1'b1;
      end
    join
    drain();

    // reset with two requests in flight
    rdy_val = 1'b0;
    @(posedge clk);
    #2;
    rand_req();
    rand_req();
    check("inflight_valid", LW'(bus0.out_valid), LW'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", LW'(bus0.out_valid), LW'(0));
    check("rst_async_be_valid", LW'(bus1.out_valid), LW'(0));
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_val = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_quiet", LW'(bus0.out_valid), LW'(0));
    end
    @(posedge clk);
    #1;
    rand_req();
    drain();

    // randomized traffic with random back-pressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      rand_req();
    end
    rdy_rand = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
